// File: rtl/water_reminder_sched_if.sv
// Signal bundle between the button/switch conditioning logic and the reminder scheduler.
// The master drives the user inputs; the slave (scheduler) drives the buzzer and status outputs.
interface water_reminder_sched_if;
    logic        enable;
    logic        ack;
    logic        snooze;
    logic        reminder;
    logic        alert;
    logic [11:0] remaining;
    logic [3:0]  missed;

    modport master (
        output enable, ack, snooze,
        input  reminder, alert, remaining, missed
    );

    modport slave (
        input  enable, ack, snooze,
        output reminder, alert, remaining, missed
    );
endinterface

// File: rtl/water_reminder_sched.sv
// Drink-interval countdown with a blinking alert, snooze, and auto-reschedule that counts missed alerts.
// Timing is derived from a half-second prescaler that restarts on every state change.
module water_reminder_sched #(
    parameter int unsigned HALF_DIV   = 12_500_000,
    parameter int unsigned INTERVAL_S = 1800,
    parameter int unsigned SNOOZE_S   = 300,
    parameter int unsigned TIMEOUT_S  = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    water_reminder_sched_if.slave bus
);
    localparam int unsigned      PW       = $clog2(HALF_DIV);
    localparam logic [PW-1:0]    PRE_LAST = PW'(HALF_DIV - 1);
    localparam logic [11:0]      INTERVAL = 12'(INTERVAL_S);
    localparam logic [11:0]      SNOOZE   = 12'(SNOOZE_S);
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_SNOOZE,
        S_ALERT
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic          half_q, half_d;
    logic [7:0]    alert_tmr_q, alert_tmr_d;
    logic [11:0]   remaining_q, remaining_d;
    logic [3:0]    missed_q, missed_d;
    logic          half_tick;
    logic          sec_tick;
    logic          restart;

    always_comb begin
        half_tick   = (prescaler_q == PRE_LAST);
        sec_tick    = half_tick & half_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        missed_d    = missed_q;
        restart     = 1'b0;

        if (!bus.enable) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_COUNT;
                    remaining_d = INTERVAL;
                end
                S_COUNT, S_SNOOZE: begin
                    if (bus.ack) begin
                        // Early drink restarts the full interval, even when already in COUNT.
                        state_d     = S_COUNT;
                        remaining_d = INTERVAL;
                        restart     = 1'b1;
                    end else if (sec_tick) begin
                        if (remaining_q <= 12'd1) begin
                            state_d     = S_ALERT;
                            remaining_d = '0;
                        end else begin
                            remaining_d = remaining_q - 12'd1;
                        end
                    end
                end
                S_ALERT: begin
                    if (bus.ack) begin
                        state_d     = S_COUNT;
                        remaining_d = INTERVAL;
                        missed_d    = '0;
                    end else if (bus.snooze) begin
                        state_d     = S_SNOOZE;
                        remaining_d = SNOOZE;
                    end else if (sec_tick && alert_tmr_q == TMO_LAST) begin
                        state_d     = S_COUNT;
                        remaining_d = INTERVAL;
                        missed_d    = (missed_q == 4'hF) ? missed_q : missed_q + 4'd1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end
            endcase
        end

        prescaler_d = half_tick ? '0 : prescaler_q + 1'b1;
        half_d      = half_q ^ half_tick;
        alert_tmr_d = (state_q == S_ALERT && sec_tick) ? alert_tmr_q + 8'd1 : alert_tmr_q;

        // Every state entry (and an in-COUNT reload) starts its timing from zero.
        if (restart || state_d != state_q) begin
            prescaler_d = '0;
            half_d      = 1'b0;
            alert_tmr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prescaler_q <= '0;
            half_q      <= 1'b0;
            alert_tmr_q <= '0;
            remaining_q <= '0;
            missed_q    <= '0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            half_q      <= half_d;
            alert_tmr_q <= alert_tmr_d;
            remaining_q <= remaining_d;
            missed_q    <= missed_d;
        end
    end

    assign bus.alert     = (state_q == S_ALERT);
    assign bus.reminder  = (state_q == S_ALERT) & ~half_q;
    assign bus.remaining = remaining_q;
    assign bus.missed    = missed_q;
endmodule
